// File: rtl/rv_shifter_pl.sv
// Multi-cycle barrel shifter for the uRV execute stage: SLL/SRL/SRA plus optional ROL/ROR,
// split over STAGES segments. Holds one op in flight and stalls X until the result is ready.
module rv_shifter_pl #(
  parameter int XLEN       = 32,
  parameter int STAGES     = 2,
  parameter bit ENABLE_ROT = 1'b0,
  localparam int SHW       = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            x_stall_i,
  input  logic            w_stall_req_i,
  output logic            x_stall_req_o,
  output logic            x_valid_o,
  input  logic            d_valid_i,
  input  logic            d_is_shift_i,
  input  logic [XLEN-1:0] d_rs1_i,
  input  logic [SHW-1:0]  d_shamt_i,
  input  logic [2:0]      d_fun_i,
  input  logic            d_shifter_sign_i,
  input  logic            d_rot_i,
  output logic [XLEN-1:0] x_rd_o
);

  localparam int         SEG     = (SHW + STAGES - 1) / STAGES;
  localparam int         CNT_W   = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [2:0] FUNC_SL = 3'b001;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  function automatic logic [XLEN-1:0] bitrev(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = x[XLEN-1-i];
    return r;
  endfunction

  // Right shift by n; vacated bits take the fill bit, or the bits shifted out when rotating.
  function automatic logic [XLEN-1:0] shr_fill(input logic [XLEN-1:0] x, input int n,
                                               input logic fill, input logic rot);
    return XLEN'({(rot ? x : {XLEN{fill}}), x} >> n);
  endfunction

  // Shamt bits are owned MSB-first, SEG bits per stage; the last stage may own none.
  function automatic logic [XLEN-1:0] stage_shift(input logic [XLEN-1:0] x,
                                                  input logic [SHW-1:0] sh, input logic fill,
                                                  input logic rot, input int stg);
    logic [XLEN-1:0] y;
    y = x;
    for (int b = 0; b < SHW; b++)
      if (((SHW - 1 - b) / SEG) == stg && sh[b]) y = shr_fill(y, 1 << b, fill, rot);
    return y;
  endfunction

  logic            req;
  logic            rot_in, left_in, fill_in;
  logic [XLEN-1:0] st_data [STAGES];
  logic [SHW-1:0]  st_sh   [STAGES];
  logic            st_fill [STAGES];
  logic            st_rot  [STAGES];
  logic            st_left [STAGES];
  logic [XLEN-1:0] st_res  [STAGES];
  logic [XLEN-1:0] result;
  logic            stall, valid;

  assign req     = d_valid_i & d_is_shift_i & ~w_stall_req_i;
  assign rot_in  = ENABLE_ROT ? d_rot_i : 1'b0;
  assign left_in = (d_fun_i == FUNC_SL);
  assign fill_in = ~left_in & d_shifter_sign_i & ~rot_in & d_rs1_i[XLEN-1];

  // Stage 0 inputs: left ops are bit-reversed so the datapath only ever shifts right
  assign st_data[0] = left_in ? bitrev(d_rs1_i) : d_rs1_i;
  assign st_sh[0]   = d_shamt_i;
  assign st_fill[0] = fill_in;
  assign st_rot[0]  = rot_in;
  assign st_left[0] = left_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign st_res[k] = stage_shift(st_data[k], st_sh[k], st_fill[k], st_rot[k], k);
  end

  // Pipe boundary k sits between segment k-1 and segment k; reloads every cycle
  for (genvar k = 1; k < STAGES; k++) begin : g_pipe
    logic [XLEN-1:0] data_q;
    logic [SHW-1:0]  sh_q;
    logic            fill_q, rot_q, left_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        data_q <= '0;
        sh_q   <= '0;
        fill_q <= 1'b0;
        rot_q  <= 1'b0;
        left_q <= 1'b0;
      end else begin
        data_q <= st_res[k-1];
        sh_q   <= st_sh[k-1];
        fill_q <= st_fill[k-1];
        rot_q  <= st_rot[k-1];
        left_q <= st_left[k-1];
      end
    end

    assign st_data[k] = data_q;
    assign st_sh[k]   = sh_q;
    assign st_fill[k] = fill_q;
    assign st_rot[k]  = rot_q;
    assign st_left[k] = left_q;
  end

  // Output: undo the left-op reversal after the last segment
  assign result = st_left[STAGES-1] ? bitrev(st_res[STAGES-1]) : st_res[STAGES-1];

  if (STAGES == 1) begin : g_comb
    logic unused_x_stall;
    assign unused_x_stall = x_stall_i;
    assign stall          = 1'b0;
    assign valid          = req;
  end else begin : g_fsm
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      valid   = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          stall = req;
          if (req) begin
            cnt_d   = CNT_W'(1);
            state_d = (CNT_W'(1) == CNT_LAST) ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          stall = req;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_LAST) state_d = S_DONE;
        end
        S_DONE: begin
          valid = 1'b1;
          if (!x_stall_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
      // Losing the request (including a W-stage stall) abandons the op from any state
      if (!req) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end
  end

  assign x_stall_req_o = ~rst_i & stall;
  assign x_valid_o     = ~rst_i & valid;
  assign x_rd_o        = rst_i ? '0 : result;

endmodule

// File: tb/tb_rv_shifter_pl.sv
// Bench for rv_shifter_pl: four configurations driven from shared stimulus, checked against
// constant vectors, hand-written timing sequences and an arithmetic reference model.
module tb_rv_shifter_pl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, x_stall, w_stall, d_valid, d_is_shift, d_sign, d_rot;
  logic [2:0]  d_fun;
  logic [63:0] rs1;
  logic [5:0]  shamt;

  logic        s1_stall, s1_valid, s2_stall, s2_valid, s3_stall, s3_valid, s4_stall, s4_valid;
  logic [31:0] s1_rd, s2_rd, s4_rd;
  logic [63:0] s3_rd;

  rv_shifter_pl #(.XLEN(32), .STAGES(1), .ENABLE_ROT(1'b1)) u_s1 (
    .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .w_stall_req_i(w_stall),
    .x_stall_req_o(s1_stall), .x_valid_o(s1_valid), .d_valid_i(d_valid),
    .d_is_shift_i(d_is_shift), .d_rs1_i(rs1[31:0]), .d_shamt_i(shamt[4:0]), .d_fun_i(d_fun),
    .d_shifter_sign_i(d_sign), .d_rot_i(d_rot), .x_rd_o(s1_rd));

  rv_shifter_pl #(.XLEN(32), .STAGES(2), .ENABLE_ROT(1'b1)) u_s2 (
    .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .w_stall_req_i(w_stall),
    .x_stall_req_o(s2_stall), .x_valid_o(s2_valid), .d_valid_i(d_valid),
    .d_is_shift_i(d_is_shift), .d_rs1_i(rs1[31:0]), .d_shamt_i(shamt[4:0]), .d_fun_i(d_fun),
    .d_shifter_sign_i(d_sign), .d_rot_i(d_rot), .x_rd_o(s2_rd));

  rv_shifter_pl #(.XLEN(64), .STAGES(3), .ENABLE_ROT(1'b0)) u_s3 (
    .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .w_stall_req_i(w_stall),
    .x_stall_req_o(s3_stall), .x_valid_o(s3_valid), .d_valid_i(d_valid),
    .d_is_shift_i(d_is_shift), .d_rs1_i(rs1), .d_shamt_i(shamt), .d_fun_i(d_fun),
    .d_shifter_sign_i(d_sign), .d_rot_i(d_rot), .x_rd_o(s3_rd));

  rv_shifter_pl #(.XLEN(32), .STAGES(4), .ENABLE_ROT(1'b1)) u_s4 (
    .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .w_stall_req_i(w_stall),
    .x_stall_req_o(s4_stall), .x_valid_o(s4_valid), .d_valid_i(d_valid),
    .d_is_shift_i(d_is_shift), .d_rs1_i(rs1[31:0]), .d_shamt_i(shamt[4:0]), .d_fun_i(d_fun),
    .d_shifter_sign_i(d_sign), .d_rot_i(d_rot), .x_rd_o(s4_rd));

  localparam logic [2:0] SL = 3'b001;
  localparam logic [2:0] SR = 3'b101;

  typedef struct {
    logic [2:0]  fun;
    logic        sign;
    logic        rot;
    logic [63:0] a;
    logic [5:0]  sh;
    logic [31:0] e32;
    logic [63:0] e64;
  } vec_t;

  vec_t vt[13];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on an xlen-wide value, shamt taken modulo xlen
  function automatic logic [63:0] ref_sh(input int xlen, input logic en_rot, input logic [2:0] f,
                                         input logic sg, input logic rt, input logic [63:0] a,
                                         input logic [5:0] sh);
    logic [127:0]       x;
    logic [63:0]        mask;
    logic signed [63:0] sx;
    int                 n;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    n    = int'(sh) % xlen;
    x    = {64'b0, a & mask};
    if (en_rot && rt) begin
      if (f == SL) x = (x << n) | (x >> (xlen - n));
      else         x = (x >> n) | (x << (xlen - n));
      return x[63:0] & mask;
    end
    if (f == SL) return (x[63:0] << n) & mask;
    if (sg) begin
      sx = (xlen == 64) ? a : {{32{a[31]}}, a[31:0]};
      sx = sx >>> n;
      return sx & mask;
    end
    return x[63:0] >> n;
  endfunction

  task automatic drive(input logic v, input logic [2:0] f, input logic sg, input logic rt,
                       input logic [63:0] a, input logic [5:0] sh);
    d_valid = v; d_is_shift = 1'b1; d_fun = f; d_sign = sg; d_rot = rt; rs1 = a; shamt = sh;
  endtask

  // Hold the op with x_stall high so every config parks in DONE, check at cycle 3, then idle
  task automatic run_vec(input string tag, input logic [2:0] f, input logic sg, input logic rt,
                         input logic [63:0] a, input logic [5:0] sh, input logic [31:0] e32,
                         input logic [63:0] e64);
    @(negedge clk);
    drive(1'b1, f, sg, rt, a, sh);
    x_stall = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_s1_rd"}, {32'b0, s1_rd}, {32'b0, e32});
    chk({tag, "_s2_rd"}, {32'b0, s2_rd}, {32'b0, e32});
    chk({tag, "_s3_rd"}, s3_rd, e64);
    chk({tag, "_s4_rd"}, {32'b0, s4_rd}, {32'b0, e32});
    chk1({tag, "_s2_valid"}, s2_valid, 1'b1);
    chk1({tag, "_s3_valid"}, s3_valid, 1'b1);
    chk1({tag, "_s4_valid"}, s4_valid, 1'b1);
    chk1({tag, "_s4_stall"}, s4_stall, 1'b0);
    chk1({tag, "_s1_stall"}, s1_stall, 1'b0);
    @(negedge clk);
    d_is_shift = 1'b0;
    x_stall    = 1'b0;
    #1;
    chk1({tag, "_noshift_s1_valid"}, s1_valid, 1'b0);
  endtask

  initial begin
    logic [2:0]  f;
    logic        sg, rt;
    logic [63:0] a, e;
    logic [5:0]  sh;
    logic [31:0] e32;

    vt[0]  = '{SR,   1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 6'd31, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vt[1]  = '{SL,   1'b0, 1'b0, 64'h0000_0000_0000_0001, 6'd63, 32'h8000_0000, 64'h8000_0000_0000_0000};
    vt[2]  = '{SR,   1'b0, 1'b0, 64'h0000_0000_0000_0001, 6'd0,  32'h0000_0001, 64'h0000_0000_0000_0001};
    vt[3]  = '{SR,   1'b0, 1'b1, 64'h0000_0000_0000_00F1, 6'd4,  32'h1000_000F, 64'h0000_0000_0000_000F};
    vt[4]  = '{SL,   1'b0, 1'b1, 64'h0000_0000_8000_0001, 6'd1,  32'h0000_0003, 64'h0000_0001_0000_0002};
    vt[5]  = '{SR,   1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 6'd0,  32'h9ABC_DEF0, 64'h1234_5678_9ABC_DEF0};
    vt[6]  = '{SR,   1'b0, 1'b1, 64'h0000_0001_0000_0001, 6'd31, 32'h0000_0002, 64'h0000_0000_0000_0002};
    vt[7]  = '{SL,   1'b0, 1'b1, 64'h0000_0000_8000_0000, 6'd31, 32'h4000_0000, 64'h4000_0000_0000_0000};
    vt[8]  = '{SR,   1'b1, 1'b0, 64'h7FFF_FFFF_7FFF_FFFF, 6'd4,  32'h07FF_FFFF, 64'h07FF_FFFF_F7FF_FFFF};
    vt[9]  = '{SR,   1'b1, 1'b0, 64'h8000_0000_0000_0000, 6'd63, 32'h0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    vt[10] = '{3'b0, 1'b0, 1'b0, 64'h0000_0000_0000_0080, 6'd3,  32'h0000_0010, 64'h0000_0000_0000_0010};
    vt[11] = '{SR,   1'b1, 1'b1, 64'h0000_0000_8000_0001, 6'd1,  32'hC000_0000, 64'h0000_0000_4000_0000};
    vt[12] = '{SL,   1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd4,  32'hFFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF0};

    // Reset with a live request: every output must read zero
    rst = 1'b1; x_stall = 1'b0; w_stall = 1'b0;
    drive(1'b1, vt[0].fun, vt[0].sign, vt[0].rot, vt[0].a, vt[0].sh);
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_s1_valid", s1_valid, 1'b0);  chk1("rst_s1_stall", s1_stall, 1'b0);
    chk1("rst_s2_valid", s2_valid, 1'b0);  chk1("rst_s2_stall", s2_stall, 1'b0);
    chk1("rst_s3_valid", s3_valid, 1'b0);  chk1("rst_s3_stall", s3_stall, 1'b0);
    chk1("rst_s4_valid", s4_valid, 1'b0);  chk1("rst_s4_stall", s4_stall, 1'b0);
    chk("rst_s1_rd", {32'b0, s1_rd}, 64'd0);
    chk("rst_s2_rd", {32'b0, s2_rd}, 64'd0);
    chk("rst_s3_rd", s3_rd, 64'd0);
    @(negedge clk);
    rst = 1'b0; d_valid = 1'b0;

    for (int i = 0; i < 13; i++)
      run_vec($sformatf("vec%0d", i), vt[i].fun, vt[i].sign, vt[i].rot, vt[i].a, vt[i].sh,
              vt[i].e32, vt[i].e64);

    // Free-running latency: with x_stall low and the op held, each config cycles with period STAGES
    @(negedge clk);
    drive(1'b1, vt[0].fun, vt[0].sign, vt[0].rot, vt[0].a, vt[0].sh);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk1($sformatf("lat_s2_valid_c%0d", k), s2_valid, (k % 2) == 1);
      chk1($sformatf("lat_s2_stall_c%0d", k), s2_stall, (k % 2) != 1);
      chk1($sformatf("lat_s3_valid_c%0d", k), s3_valid, (k % 3) == 2);
      chk1($sformatf("lat_s3_stall_c%0d", k), s3_stall, (k % 3) != 2);
      chk1($sformatf("lat_s4_valid_c%0d", k), s4_valid, (k % 4) == 3);
      chk1($sformatf("lat_s4_stall_c%0d", k), s4_stall, (k % 4) != 3);
      chk1($sformatf("lat_s1_valid_c%0d", k), s1_valid, 1'b1);
      if ((k % 2) == 1) chk($sformatf("lat_s2_rd_c%0d", k), {32'b0, s2_rd}, {32'b0, vt[0].e32});
      if ((k % 3) == 2) chk($sformatf("lat_s3_rd_c%0d", k), s3_rd, vt[0].e64);
      if (k == 3) chk("lat_s4_rd", {32'b0, s4_rd}, {32'b0, vt[0].e32});
      @(negedge clk);
    end
    d_valid = 1'b0;

    // STAGES=2 parked in DONE by x_stall for three cycles, then released
    @(negedge clk);
    drive(1'b1, vt[4].fun, vt[4].sign, vt[4].rot, vt[4].a, vt[4].sh);
    for (int k = 0; k < 6; k++) begin
      x_stall = (k < 4);
      #1;
      chk1($sformatf("hold_s2_valid_c%0d", k), s2_valid, (k >= 1 && k <= 4));
      chk1($sformatf("hold_s2_stall_c%0d", k), s2_stall, (k == 0 || k == 5));
      if (k >= 1 && k <= 4) chk($sformatf("hold_s2_rd_c%0d", k), {32'b0, s2_rd}, 64'd3);
      @(negedge clk);
    end
    d_valid = 1'b0; x_stall = 1'b0;

    // W-stage stall pulse while STAGES=4 is busy: op dropped, then a full restart
    @(negedge clk);
    drive(1'b1, vt[3].fun, vt[3].sign, vt[3].rot, vt[3].a, vt[3].sh);
    for (int k = 0; k < 7; k++) begin
      w_stall = (k == 2);
      #1;
      chk1($sformatf("wst_s4_stall_c%0d", k), s4_stall, (k != 2 && k != 6));
      chk1($sformatf("wst_s4_valid_c%0d", k), s4_valid, (k == 6));
      chk1($sformatf("wst_s1_valid_c%0d", k), s1_valid, (k != 2));
      if (k == 6) chk("wst_s4_rd", {32'b0, s4_rd}, {32'b0, vt[3].e32});
      @(negedge clk);
    end
    d_valid = 1'b0; w_stall = 1'b0;

    // Reset while busy: outputs forced low, no stall afterwards until a new request
    @(negedge clk);
    drive(1'b1, vt[8].fun, vt[8].sign, vt[8].rot, vt[8].a, vt[8].sh);
    for (int k = 0; k < 6; k++) begin
      rst     = (k == 2 || k == 3);
      d_valid = (k != 4);
      #1;
      if (k == 2 || k == 3) begin
        chk1($sformatf("rbusy_s4_stall_c%0d", k), s4_stall, 1'b0);
        chk1($sformatf("rbusy_s4_valid_c%0d", k), s4_valid, 1'b0);
        chk($sformatf("rbusy_s4_rd_c%0d", k), {32'b0, s4_rd}, 64'd0);
        chk($sformatf("rbusy_s3_rd_c%0d", k), s3_rd, 64'd0);
        chk1($sformatf("rbusy_s1_valid_c%0d", k), s1_valid, 1'b0);
      end
      if (k == 4) begin
        chk1("rbusy_s2_stall_c4", s2_stall, 1'b0);
        chk1("rbusy_s3_stall_c4", s3_stall, 1'b0);
        chk1("rbusy_s4_stall_c4", s4_stall, 1'b0);
        chk1("rbusy_s4_valid_c4", s4_valid, 1'b0);
      end
      if (k == 5) begin
        chk1("rbusy_s2_stall_c5", s2_stall, 1'b1);
        chk1("rbusy_s3_stall_c5", s3_stall, 1'b1);
        chk1("rbusy_s4_stall_c5", s4_stall, 1'b1);
        chk1("rbusy_s1_valid_c5", s1_valid, 1'b1);
      end
      @(negedge clk);
    end
    d_valid = 1'b0;

    // Random sweep against the reference model
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    f = SL;
        2, 3:    f = SR;
        default: f = 3'($urandom);
      endcase
      sg = 1'($urandom);
      rt = 1'($urandom);
      a  = {$urandom, $urandom};
      case (i % 8)
        0:       sh = 6'd0;
        1:       sh = 6'd31;
        2:       sh = 6'd63;
        default: sh = 6'($urandom);
      endcase
      e   = ref_sh(32, 1'b1, f, sg, rt, a, sh);
      e32 = e[31:0];
      e   = ref_sh(64, 1'b0, f, sg, rt, a, sh);
      run_vec($sformatf("rnd%0d", i), f, sg, rt, a, sh, e32, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

endmodule
